dmac_ctrl: RTL and testbench

- CSR-programmed sequencer for the DMAC datapath.
- Accepts source, destination and length over an Avalon-MM slave port, launches the read master and write master together, and holds their Start lines during the transfer.
- Detects completion, timeout or abort, updates status, and raises an interrupt.
- Sits between the system interconnect (CPU slave) and the READ/WRITE master pair that share the DMAC FIFO.

---
 rtl/dmac_ctrl.sv | 166 ++++++++++++++++
 tb/tb_dmac_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmac_ctrl.sv
// DMAC sequencer: CSR slave programs SRC/DST/LEN; GO launches read+write masters, holds start until done/abort/timeout.
// CSR read latency 1 cycle; no stall, config writes are dropped while BUSY; IRQ lags DONE by one cycle.
module dmac_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter int unsigned ADDR_W         = 3
) (
  input  logic              iClk,
  input  logic              iReset_n,
  input  logic              iCS_chipselect,
  input  logic              iCS_write,
  input  logic              iCS_read,
  input  logic [ADDR_W-1:0] iCS_address,
  input  logic [31:0]       iCS_writedata,
  output logic [31:0]       oCS_readdata,
  output logic              oRM_start,
  output logic [31:0]       oRM_startaddress,
  output logic [31:0]       oRM_length,
  output logic              oWM_start,
  output logic [31:0]       oWM_startaddress,
  output logic [31:0]       oWM_length,
  input  logic              iWM_done,
  output logic              oIrq
);

  localparam logic [ADDR_W-1:0] A_SRC    = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_DST    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_LEN    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(4);
  localparam logic [31:0]       TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RUN, S_FINISH} state_e;

  state_e      state_q, state_d;
  logic [31:0] src_q, src_d, dst_q, dst_d, len_q, len_d;
  logic [31:0] cnt_q, cnt_d, rdata_q, rdata_d;
  logic        ie_q, ie_d, busy_q, busy_d, done_q, done_d;
  logic        err_q, err_d, tmo_q, tmo_d, irq_q, irq_d;
  logic        wr, rd, go_wr, abort_wr, clr_wr, tmo_hit;

  assign wr       = iCS_chipselect & iCS_write;
  assign rd       = iCS_chipselect & iCS_read;
  assign go_wr    = wr && (iCS_address == A_CTRL) && iCS_writedata[0];
  assign abort_wr = wr && (iCS_address == A_CTRL) && iCS_writedata[2];
  assign clr_wr   = wr && (iCS_address == A_STATUS) && iCS_writedata[1];
  assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (cnt_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    ie_d    = ie_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    irq_d   = ie_q & done_q;

    if (wr && !busy_q) begin
      case (iCS_address)
        A_SRC:   src_d = iCS_writedata;
        A_DST:   dst_d = iCS_writedata;
        A_LEN:   len_d = iCS_writedata;
        A_CTRL:  ie_d  = iCS_writedata[1];
        default: ;
      endcase
    end

    // Software clear is applied first so a same-cycle hardware set still lands.
    if (clr_wr) begin
      done_d = 1'b0;
      err_d  = 1'b0;
      tmo_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (go_wr && !busy_q) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (len_q == 32'd0 || len_q[1:0] != 2'b00) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 32'd1;
        if (iWM_done) begin
          state_d = S_FINISH;
        end else if (abort_wr) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (rd) begin
      case (iCS_address)
        A_SRC:    rdata_d = src_q;
        A_DST:    rdata_d = dst_q;
        A_LEN:    rdata_d = len_q;
        A_CTRL:   rdata_d = {30'd0, ie_q, 1'b0};
        A_STATUS: rdata_d = {28'd0, tmo_q, err_q, done_q, busy_q};
        default:  rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      ie_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      ie_q    <= ie_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      irq_q   <= irq_d;
    end
  end

  assign oCS_readdata     = rdata_q;
  assign oRM_start        = (state_q == S_RUN);
  assign oWM_start        = (state_q == S_RUN);
  assign oRM_startaddress = src_q;
  assign oWM_startaddress = dst_q;
  assign oRM_length       = len_q;
  assign oWM_length       = len_q;
  assign oIrq             = irq_q;

endmodule

// File: tb/tb_dmac_ctrl.sv
// Bench for dmac_ctrl: a default-timeout instance plus an 8-cycle-timeout instance sharing the CSR bus.
module tb_dmac_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs_sel, cs_wr, cs_rd;
  logic [2:0]  cs_addr;
  logic [31:0] cs_wdata;
  logic        wm_done, wm_done8;

  logic [31:0] rdata, rdata8;
  logic        rm_start, wm_start, rm_start8, wm_start8;
  logic [31:0] rm_addr, wm_addr, rm_len, wm_len;
  logic [31:0] rm_addr8, wm_addr8, rm_len8, wm_len8;
  logic        irq, irq8;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmac_ctrl dut (
    .iClk(clk), .iReset_n(rst_n),
    .iCS_chipselect(cs_sel), .iCS_write(cs_wr), .iCS_read(cs_rd),
    .iCS_address(cs_addr), .iCS_writedata(cs_wdata), .oCS_readdata(rdata),
    .oRM_start(rm_start), .oRM_startaddress(rm_addr), .oRM_length(rm_len),
    .oWM_start(wm_start), .oWM_startaddress(wm_addr), .oWM_length(wm_len),
    .iWM_done(wm_done), .oIrq(irq)
  );

  dmac_ctrl #(.TIMEOUT_CYCLES(8)) dut8 (
    .iClk(clk), .iReset_n(rst_n),
    .iCS_chipselect(cs_sel), .iCS_write(cs_wr), .iCS_read(cs_rd),
    .iCS_address(cs_addr), .iCS_writedata(cs_wdata), .oCS_readdata(rdata8),
    .oRM_start(rm_start8), .oRM_startaddress(rm_addr8), .oRM_length(rm_len8),
    .oWM_start(wm_start8), .oWM_startaddress(wm_addr8), .oWM_length(wm_len8),
    .iWM_done(wm_done8), .oIrq(irq8)
  );

  typedef struct {
    logic [31:0] exp;
    bit          sel8;
    string       name;
  } rd_exp_t;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  rd_exp_t rd_q[$];
  vec_t    vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
    cs_sel = 1'b1; cs_wr = 1'b1; cs_addr = a; cs_wdata = d;
    tick();
    cs_sel = 1'b0; cs_wr = 1'b0;
  endtask

  // Expected value is queued when the read is issued and retired when readdata updates.
  task automatic csr_read(input logic [2:0] a, input logic [31:0] exp, input bit sel8, input string name);
    rd_exp_t e;
    rd_exp_t r;
    e.exp = exp; e.sel8 = sel8; e.name = name;
    rd_q.push_back(e);
    cs_sel = 1'b1; cs_rd = 1'b1; cs_addr = a;
    tick();
    cs_sel = 1'b0; cs_rd = 1'b0;
    r = rd_q.pop_front();
    chk(r.name, r.sel8 ? rdata8 : rdata, r.exp);
  endtask

  task automatic pulse_done();
    wm_done = 1'b1;
    tick();
    wm_done = 1'b0;
  endtask

  initial begin
    int drops;
    int hi8;
    rst_n = 1'b0; cs_sel = 1'b0; cs_wr = 1'b0; cs_rd = 1'b0;
    cs_addr = '0; cs_wdata = '0; wm_done = 1'b0; wm_done8 = 1'b0;

    vecs[0] = '{3'd0, 32'h0000_1000, 32'h0000_1000};
    vecs[1] = '{3'd1, 32'h0000_2000, 32'h0000_2000};
    vecs[2] = '{3'd2, 32'h0000_0010, 32'h0000_0010};
    vecs[3] = '{3'd3, 32'h0000_0002, 32'h0000_0002};
    vecs[4] = '{3'd3, 32'hFFFF_FFF8, 32'h0000_0000};
    vecs[5] = '{3'd3, 32'h0000_0006, 32'h0000_0002};
    vecs[6] = '{3'd4, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[7] = '{3'd5, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[8] = '{3'd6, 32'hA5A5_A5A5, 32'h0000_0000};
    vecs[9] = '{3'd7, 32'h1234_5678, 32'h0000_0000};

    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_rm_start", {31'd0, rm_start}, 32'd0);
    chk("rst_wm_start", {31'd0, wm_start}, 32'd0);
    chk("rst_rm_addr", rm_addr, 32'd0);
    chk("rst_wm_len", wm_len, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    csr_read(3'd4, 32'd0, 1'b0, "rst_status");
    csr_read(3'd2, 32'd0, 1'b0, "rst_len");

    // Register map: write then read back
    for (int i = 0; i < 10; i++) begin
      csr_write(vecs[i].addr, vecs[i].wdata);
      csr_read(vecs[i].addr, vecs[i].exp, 1'b0, $sformatf("map_vec%0d", i));
    end

    // Normal transfer with interrupt
    csr_write(3'd0, 32'h0000_1000);
    csr_write(3'd1, 32'h0000_2000);
    csr_write(3'd2, 32'd16);
    csr_write(3'd3, 32'h3);
    chk("t1_check_no_start", {31'd0, rm_start}, 32'd0);
    tick();
    chk("t1_rm_start", {31'd0, rm_start}, 32'd1);
    chk("t1_wm_start", {31'd0, wm_start}, 32'd1);
    chk("t1_rm_addr", rm_addr, 32'h0000_1000);
    chk("t1_wm_addr", wm_addr, 32'h0000_2000);
    chk("t1_rm_len", rm_len, 32'd16);
    chk("t1_wm_len", wm_len, 32'd16);
    csr_read(3'd4, 32'h1, 1'b0, "t1_status_busy");
    drops = 0;
    for (int i = 0; i < 37; i++) begin
      tick();
      if (!(rm_start && wm_start)) drops++;
    end
    chk("t1_start_held", drops, 32'd0);
    pulse_done();
    chk("t1_finish_start", {31'd0, rm_start | wm_start}, 32'd0);
    chk("t1_finish_irq", {31'd0, irq}, 32'd0);
    tick();
    chk("t1_done_irq_lag", {31'd0, irq}, 32'd0);
    tick();
    chk("t1_irq", {31'd0, irq}, 32'd1);
    csr_read(3'd4, 32'h2, 1'b0, "t1_status_done");
    csr_write(3'd4, 32'h2);
    tick();
    chk("t1_irq_cleared", {31'd0, irq}, 32'd0);
    csr_write(3'd4, 32'h2);

    // Illegal lengths
    csr_write(3'd3, 32'h0);
    for (int k = 0; k < 2; k++) begin
      csr_write(3'd2, (k == 0) ? 32'd0 : 32'd6);
      csr_write(3'd3, 32'h1);
      hi8 = 0;
      for (int i = 0; i < 4; i++) begin
        if (rm_start || wm_start) hi8++;
        tick();
      end
      chk($sformatf("t2_no_start_%0d", k), hi8, 32'd0);
      csr_read(3'd4, 32'h6, 1'b0, $sformatf("t2_status_%0d", k));
      csr_write(3'd4, 32'h2);
    end

    // Timeout on the 8-cycle instance
    csr_write(3'd2, 32'd8);
    csr_write(3'd3, 32'h1);
    hi8 = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rm_start8 && wm_start8) hi8++;
    end
    chk("t3_start_cycles", hi8, 32'd8);
    csr_read(3'd4, 32'hE, 1'b1, "t3_status_timeout");
    csr_read(3'd4, 32'h1, 1'b0, "t3_default_still_busy");
    pulse_done();
    tick();
    csr_read(3'd4, 32'h2, 1'b0, "t3_default_done");
    csr_write(3'd4, 32'h2);

    // ABORT and iWM_done in the same cycle
    csr_write(3'd2, 32'd16);
    csr_write(3'd3, 32'h1);
    tick();
    tick();
    cs_sel = 1'b1; cs_wr = 1'b1; cs_addr = 3'd3; cs_wdata = 32'h4; wm_done = 1'b1;
    tick();
    cs_sel = 1'b0; cs_wr = 1'b0; wm_done = 1'b0;
    chk("t4_finish_start", {31'd0, rm_start | wm_start}, 32'd0);
    tick();
    csr_read(3'd4, 32'h2, 1'b0, "t4_status_done_wins");
    csr_read(3'd4, 32'h6, 1'b1, "t4_status_abort");
    csr_write(3'd4, 32'h2);

    // Config writes blocked while busy
    csr_write(3'd3, 32'h1);
    tick();
    csr_write(3'd0, 32'hDEAD_0000);
    csr_read(3'd0, 32'h0000_1000, 1'b0, "t5_src_blocked");
    chk("t5_rm_addr_stable", rm_addr, 32'h0000_1000);
    pulse_done();
    tick();
    csr_write(3'd4, 32'h2);
    csr_write(3'd0, 32'hDEAD_0000);
    csr_read(3'd0, 32'hDEAD_0000, 1'b0, "t5_src_after");

    // Reset mid-RUN
    csr_write(3'd3, 32'h3);
    tick();
    tick();
    chk("t6_running", {31'd0, rm_start}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_rm_start", {31'd0, rm_start}, 32'd0);
    chk("t6_wm_start", {31'd0, wm_start}, 32'd0);
    chk("t6_rm_addr", rm_addr, 32'd0);
    chk("t6_wm_addr", wm_addr, 32'd0);
    chk("t6_len", rm_len, 32'd0);
    csr_read(3'd4, 32'd0, 1'b0, "t6_status");
    csr_read(3'd3, 32'd0, 1'b0, "t6_ctrl");
    pulse_done();
    tick();
    tick();
    chk("t6_late_done_start", {31'd0, rm_start | wm_start}, 32'd0);
    chk("t6_late_done_irq", {31'd0, irq}, 32'd0);
    csr_read(3'd4, 32'd0, 1'b0, "t6_late_done_status");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
